// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response and memory-side signal bundle for mem_lsu.
// Ports: req_* (pipeline request), resp_* (completion), mem_* (word memory).
// Modports: slave = the LSU itself, master = its environment (pipeline + memory).
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MIPS lb/lh/lw/lbu/lhu/sb/sh/sw load-store unit in front of a single-ported word memory.
// Latency: accept at N, earliest mem_ack at N+1, resp_valid at N+2; illegal or trapped ops respond at N+1.
// Backpressure: req_ready only in IDLE (one access in flight); memory stalls via mem_ack, bounded by a watchdog.
// Ports: clk, rst_n (async active-low); bus (mem_lsu_if.slave) carrying req_*, resp_* and mem_* signals.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word ops respond with error and no
// memory access; when undefined, the offending low address bits are ignored and the access proceeds.
module mem_lsu (
  input  logic     clk,
  input  logic     rst_n,
  mem_lsu_if.slave bus
);
  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_SB  = 6'd40;
  localparam logic [5:0] OP_SH  = 6'd41;
  localparam logic [5:0] OP_SW  = 6'd43;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q;
  logic [1:0]  lane_q;
  logic [3:0]  wdog_q;
  logic        mem_en_q, mem_we_q;
  logic [13:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        is_load, is_store, is_half, is_word, reject;
  logic [1:0]  lane_eff;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rd_sh;
  logic [31:0] load_data;
  logic        wdog_expired;
  logic        unused_addr_bits;

  // Only a 16 KiB window is addressed; the upper request address bits are dropped.
  assign unused_addr_bits = ^bus.req_addr[31:14];

  // Opcode decode.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (bus.req_op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1;  is_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1;  is_word = 1'b1; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  // Effective lane: halfwords ignore addr[0], words ignore addr[1:0]. With trapping
  // enabled those misaligned cases are rejected before the lane is ever used.
  always_comb begin
    lane_eff = bus.req_addr[1:0];
    if (is_half) lane_eff = {bus.req_addr[1], 1'b0};
    if (is_word) lane_eff = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
    reject = !(is_load || is_store)
           || (is_half && bus.req_addr[0])
           || (is_word && (bus.req_addr[1:0] != 2'b00));
`else
    reject = !(is_load || is_store);
`endif
    be_d    = 4'hF;
    wdata_d = bus.req_wdata;
    if (is_store && is_half) begin
      be_d    = 4'b0011 << lane_eff;
      wdata_d = {2{bus.req_wdata[15:0]}};
    end else if (is_store && !is_word) begin
      be_d    = 4'b0001 << lane_eff;
      wdata_d = {4{bus.req_wdata[7:0]}};
    end else if (is_load) begin
      wdata_d = '0;
    end
  end

  // Load extraction: shifting by 8*lane puts the addressed byte/half at bit 0
  // (halfword lanes are always 0 or 2, so one shifter serves both widths).
  always_comb begin
    rd_sh = bus.mem_rdata >> {lane_q, 3'b000};
    case (op_q)
      OP_LB:   load_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
      OP_LBU:  load_data = {24'h0, rd_sh[7:0]};
      OP_LH:   load_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
      OP_LHU:  load_data = {16'h0, rd_sh[15:0]};
      OP_LW:   load_data = bus.mem_rdata;
      default: load_data = '0;
    endcase
  end

  assign wdog_expired = (wdog_q == 4'hF);

  // Next-state logic; mem_ack takes priority over the watchdog in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = reject ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ack || wdog_expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      lane_q       <= '0;
      wdog_q       <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            lane_q <= lane_eff;
            if (reject) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              mem_en_q    <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {bus.req_addr[13:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              wdog_q      <= '0;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
          end else if (wdog_expired) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            wdog_q <= wdog_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule
